// File: rtl/multiplexer_sequencer.sv
// multiplexer_sequencer: drives a binary valve tree so one leaf route is open,
// with a full-isolation settle phase between any two route patterns.
module multiplexer_sequencer #(
  parameter int LEVELS = 5,
  parameter int SETTLE = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [LEVELS-1:0] req_addr,
  output logic              req_ready,
  input  logic              release_i,
  output logic [LEVELS-1:0] ctrl0,
  output logic [LEVELS-1:0] ctrl1,
  output logic              route_active,
  output logic [LEVELS-1:0] cur_addr,
  output logic              busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLOSE = 3'd1;
  localparam logic [2:0] S_OPEN  = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  localparam logic [7:0] SETTLE_C = 8'(SETTLE);

  logic [2:0]        state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [LEVELS-1:0] addr_q, addr_d;
  logic [LEVELS-1:0] ctrl0_q, ctrl0_d;
  logic [LEVELS-1:0] ctrl1_q, ctrl1_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              active_q, active_d;
  logic              accept;

  // Level 1 is steered by the address MSB, so ctrl0 is the bit-reversed address.
  function automatic logic [LEVELS-1:0] pat0(input logic [LEVELS-1:0] a);
    logic [LEVELS-1:0] p;
    p = '0;
    for (int l = 1; l <= LEVELS; l++) begin
      p[l-1] = a[LEVELS-l];
    end
    return p;
  endfunction

  assign accept = req_valid & ready_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          addr_d  = req_addr;
          cnt_d   = SETTLE_C;
          state_d = S_CLOSE;
        end
      end
      S_CLOSE: begin
        if (cnt_q <= 8'd1) begin
          cnt_d   = SETTLE_C;
          state_d = S_OPEN;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_OPEN: begin
        if (cnt_q <= 8'd1) begin
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_HOLD: begin
        if (accept) begin
          if (req_addr != addr_q) begin
            addr_d  = req_addr;
            cnt_d   = SETTLE_C;
            state_d = S_CLOSE;
          end
        end else if (release_i) begin
          cnt_d   = SETTLE_C;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (cnt_q <= 8'd1) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they can be registered.
  always_comb begin
    ready_d  = (state_d == S_IDLE) || (state_d == S_HOLD);
    busy_d   = (state_d == S_CLOSE) || (state_d == S_OPEN);
    active_d = (state_d == S_HOLD);
    ctrl0_d  = '1;
    ctrl1_d  = '1;
    if ((state_d == S_OPEN) || (state_d == S_HOLD)) begin
      ctrl0_d = pat0(addr_d);
      ctrl1_d = ~pat0(addr_d);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      ctrl0_q  <= '1;
      ctrl1_q  <= '1;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      ctrl0_q  <= ctrl0_d;
      ctrl1_q  <= ctrl1_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      active_q <= active_d;
    end
  end

  assign req_ready    = ready_q;
  assign busy         = busy_q;
  assign route_active = active_q;
  assign ctrl0        = ctrl0_q;
  assign ctrl1        = ctrl1_q;
  assign cur_addr     = addr_q;

endmodule
